bsg_parallel_in_serial_out_buffered: RTL and testbench



---
 rtl/bsg_parallel_in_serial_out_buffered.sv | 96 +++++++++
 tb/tb_bsg_parallel_in_serial_out_buffered.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bsg_parallel_in_serial_out_buffered.sv
// Wide-to-narrow serializer: accepts els_p x width_p words and emits them one
// element per consumed beat, with one or two word buffers.
module bsg_parallel_in_serial_out_buffered #(
  parameter int width_p                 = 8,
  parameter int els_p                   = 4,
  parameter int hi_to_lo_p              = 0,
  parameter int use_minimal_buffering_p = 0
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     v_i,
  output logic                     ready_and_o,
  input  logic [els_p*width_p-1:0] data_i,
  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  output logic                     last_o,
  input  logic                     yumi_i
);

  localparam int                    n_lp        = (use_minimal_buffering_p != 0) ? 1 : 2;
  localparam int                    cnt_w_lp    = (els_p > 1) ? $clog2(els_p) : 1;
  localparam logic [cnt_w_lp-1:0]   last_cnt_lp = cnt_w_lp'(els_p - 1);
  localparam logic [1:0]            n_occ_lp    = 2'(n_lp);

  logic [els_p*width_p-1:0] buf_q [n_lp];
  logic [els_p*width_p-1:0] buf_d [n_lp];
  logic                     wptr_q, wptr_d;
  logic                     rptr_q, rptr_d;
  logic [1:0]               occ_q, occ_d;
  logic [cnt_w_lp-1:0]      cnt_q, cnt_d;
  logic [cnt_w_lp-1:0]      sel;
  logic [els_p*width_p-1:0] cur_word;
  logic                     push, pop, retire;

  // Input side: a word transfers when v_i & ready_and_o; output side: an element
  // transfers when yumi_i, which the consumer may raise only while v_o is high.
  // Both ready_and_o and v_o depend on registered occupancy alone.
  assign ready_and_o = (occ_q != n_occ_lp);
  assign v_o         = (occ_q != 2'd0);
  assign push        = v_i & ready_and_o;
  assign pop         = yumi_i & v_o;
  assign retire      = pop & (cnt_q == last_cnt_lp);
  assign last_o      = v_o & (cnt_q == last_cnt_lp);

  assign cur_word = buf_q[rptr_q];
  assign sel      = (hi_to_lo_p != 0) ? (last_cnt_lp - cnt_q) : cnt_q;

  always_comb begin
    data_o = '0;
    for (int k = 0; k < els_p; k++) begin
      if (sel == cnt_w_lp'(k)) data_o = cur_word[k*width_p +: width_p];
    end
  end

  always_comb begin
    buf_d  = buf_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    occ_d  = occ_q;
    if (push) begin
      buf_d[wptr_q] = data_i;
      if (n_lp == 2) wptr_d = ~wptr_q;
    end
    if (pop) cnt_d = retire ? '0 : cnt_q + 1'b1;
    if (retire && (n_lp == 2)) rptr_d = ~rptr_q;
    // A push and a retire in the same cycle leave occupancy unchanged.
    case ({push, retire})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      occ_q  <= 2'd0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
      cnt_q  <= cnt_d;
    end
  end

  // Word storage carries no reset; occupancy decides what is meaningful.
  always_ff @(posedge clk_i) begin
    buf_q <= buf_d;
  end

  yumi_requires_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);

endmodule

// File: tb/tb_bsg_parallel_in_serial_out_buffered.sv
// Bench for the serializer: a two-buffer low-first instance and a one-buffer
// high-first instance driven side by side against a word/element queue model.
module tb_bsg_parallel_in_serial_out_buffered;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        v_i    [2];
  logic [31:0] data_i [2];
  logic        yumi_i [2];
  logic        ready_o[2];
  logic        v_o    [2];
  logic        last_o [2];
  logic [7:0]  data_o [2];

  bsg_parallel_in_serial_out_buffered #(
    .width_p(8), .els_p(4), .hi_to_lo_p(0), .use_minimal_buffering_p(0)
  ) dut_wide (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v_i[0]), .ready_and_o(ready_o[0]),
    .data_i(data_i[0]), .v_o(v_o[0]), .data_o(data_o[0]), .last_o(last_o[0]),
    .yumi_i(yumi_i[0])
  );

  bsg_parallel_in_serial_out_buffered #(
    .width_p(8), .els_p(4), .hi_to_lo_p(1), .use_minimal_buffering_p(1)
  ) dut_min (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v_i[1]), .ready_and_o(ready_o[1]),
    .data_i(data_i[1]), .v_o(v_o[1]), .data_o(data_o[1]), .last_o(last_o[1]),
    .yumi_i(yumi_i[1])
  );

  // Reference model: words in flight per instance and the expected element stream.
  int          words [2];
  int          nmax  [2] = '{2, 1};
  bit          hi    [2] = '{1'b0, 1'b1};
  logic [8:0]  exp_q0[$];
  logic [8:0]  exp_q1[$];
  logic [8:0]  log0[$];
  logic [8:0]  log1[$];
  int          checks = 0;
  int          errors = 0;
  int          push_mode;
  int          yumi_mode;
  bit          force_en;
  logic [31:0] force_word;
  bit          count_idle;
  int          idle [2];
  logic [8:0]  lo_tab [4] = '{9'h011, 9'h022, 9'h033, 9'h144};
  logic [8:0]  hi_tab [4] = '{9'h044, 9'h033, 9'h022, 9'h111};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_push(input int i, input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      int         s;
      logic [8:0] e;
      s = hi[i] ? 3 - k : k;
      e = {(k == 3), w[s*8 +: 8]};
      if (i == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
    end
    words[i]++;
  endtask

  task automatic step();
    logic [8:0] f;
    bit         can_push;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("ready%0d", i), 32'(ready_o[i]), 32'(words[i] < nmax[i]));
      check_eq($sformatf("v%0d", i), 32'(v_o[i]), 32'(words[i] > 0));
      if (words[i] > 0) begin
        f = (i == 0) ? exp_q0[0] : exp_q1[0];
        check_eq($sformatf("data%0d", i), 32'(data_o[i]), 32'(f[7:0]));
        check_eq($sformatf("last%0d", i), 32'(last_o[i]), 32'(f[8]));
      end
      if (v_o[i]) begin
        if (i == 0) log0.push_back({last_o[0], data_o[0]});
        else        log1.push_back({last_o[1], data_o[1]});
      end else if (count_idle) begin
        idle[i]++;
      end
    end
    for (int i = 0; i < 2; i++) begin
      can_push  = (words[i] < nmax[i]);
      v_i[i]    = (push_mode == 1) || ((push_mode == 2) && ($urandom_range(0, 1) == 1));
      data_i[i] = force_en ? force_word : $urandom;
      yumi_i[i] = v_o[i] && (words[i] > 0) && ((yumi_mode == 1) || ($urandom_range(0, 1) == 1));
      if (yumi_i[i]) begin
        if (i == 0) f = exp_q0.pop_front();
        else        f = exp_q1.pop_front();
        if (f[8]) words[i]--;
      end
      if (v_i[i] && can_push) model_push(i, data_i[i]);
    end
  endtask

  task automatic push_one(input logic [31:0] w);
    force_en   = 1'b1;
    force_word = w;
    push_mode  = 1;
    step();
    push_mode  = 0;
    force_en   = 1'b0;
  endtask

  initial begin
    v_i        = '{1'b1, 1'b1};
    data_i     = '{32'h0, 32'h0};
    yumi_i     = '{1'b0, 1'b0};
    words      = '{0, 0};
    idle       = '{0, 0};
    push_mode  = 0;
    yumi_mode  = 1;
    force_en   = 1'b0;
    force_word = '0;
    count_idle = 1'b0;

    // Reset with v_i held high: no word may be taken.
    #1;
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("rst_v%0d", i), 32'(v_o[i]), 32'(0));
      check_eq($sformatf("rst_ready%0d", i), 32'(ready_o[i]), 32'(1));
      check_eq($sformatf("rst_last%0d", i), 32'(last_o[i]), 32'(0));
    end
    repeat (3) @(negedge clk);
    v_i   = '{1'b0, 1'b0};
    rst_n = 1'b1;
    step();

    // Single word, consumer always ready: element order per instance.
    log0.delete();
    log1.delete();
    push_one(32'h44332211);
    repeat (5) step();
    check_eq("lo_count", 32'(log0.size()), 32'(4));
    check_eq("hi_count", 32'(log1.size()), 32'(4));
    for (int k = 0; k < 4; k++) begin
      if (k < log0.size()) check_eq($sformatf("lo_elem%0d", k), 32'(log0[k]), 32'(lo_tab[k]));
      if (k < log1.size()) check_eq($sformatf("hi_elem%0d", k), 32'(log1[k]), 32'(hi_tab[k]));
    end

    // Continuous push and pop: no bubbles with two buffers, one per word with one.
    push_mode = 1;
    yumi_mode = 1;
    step();
    idle       = '{0, 0};
    count_idle = 1'b1;
    repeat (20) step();
    count_idle = 1'b0;
    check_eq("wide_idle", 32'(idle[0]), 32'(0));
    check_eq("min_idle", 32'(idle[1]), 32'(4));
    push_mode = 0;
    repeat (10) step();

    // Random traffic with back-pressure.
    push_mode = 2;
    yumi_mode = 2;
    repeat (400) step();
    push_mode = 0;
    yumi_mode = 1;
    repeat (12) step();

    // Reset after two of four elements have been consumed.
    push_one(32'h88776655);
    repeat (2) step();
    @(negedge clk);
    rst_n  = 1'b0;
    v_i    = '{1'b1, 1'b1};
    yumi_i = '{1'b0, 1'b0};
    #1;
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("mid_rst_v%0d", i), 32'(v_o[i]), 32'(0));
      check_eq($sformatf("mid_rst_ready%0d", i), 32'(ready_o[i]), 32'(1));
      check_eq($sformatf("mid_rst_last%0d", i), 32'(last_o[i]), 32'(0));
    end
    exp_q0.delete();
    exp_q1.delete();
    words = '{0, 0};
    @(negedge clk);
    v_i   = '{1'b0, 1'b0};
    rst_n = 1'b1;
    step();
    log0.delete();
    log1.delete();
    push_one(32'hddccbbaa);
    step();
    check_eq("post_rst_count0", 32'(log0.size()), 32'(1));
    check_eq("post_rst_count1", 32'(log1.size()), 32'(1));
    if (log0.size() > 0) check_eq("post_rst_first0", 32'(log0[0]), 32'(9'h0aa));
    if (log1.size() > 0) check_eq("post_rst_first1", 32'(log1[0]), 32'(9'h0dd));
    repeat (6) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
